// File: rtl/fpu.sv
// Single-cycle IEEE-754 single-precision add/sub/mul/div unit with a registered result.
// Flush-to-zero inputs, truncating rounding, +0 for zero/underflow, qNaN for Inf/NaN operands.
module fpu (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        zero_division
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    op_e         op_sel;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_zero, b_zero, a_spec, b_spec;

    assign op_sel = op_e'(op);
    assign sa     = A[31];
    assign sb     = B[31];
    assign ea     = A[30:23];
    assign eb     = B[30:23];
    assign ma     = {1'b1, A[22:0]};
    assign mb     = {1'b1, B[22:0]};
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_spec = (ea == 8'hFF);
    assign b_spec = (eb == 8'hFF);

    // ---------------------------------------------------------------- add/sub
    logic               sb_eff, a_ge_b, s_big, lz_found;
    logic [7:0]         e_big, e_small, exp_diff;
    logic [23:0]        m_big, m_small, aligned, diff_m;
    logic [24:0]        sum;
    logic [4:0]         lzc;
    logic signed [10:0] add_exp;
    logic [31:0]        add_res;

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch can be inferred.
    always_comb begin
        sb_eff   = sb ^ (op_sel == OP_SUB);
        a_ge_b   = ({ea, ma} >= {eb, mb});
        s_big    = a_ge_b ? sa : sb_eff;
        e_big    = a_ge_b ? ea : eb;
        m_big    = a_ge_b ? ma : mb;
        e_small  = a_ge_b ? eb : ea;
        m_small  = a_ge_b ? mb : ma;
        exp_diff = e_big - e_small;
        aligned  = m_small >> exp_diff;
        sum      = {1'b0, m_big} + {1'b0, aligned};
        diff_m   = m_big - aligned;

        lzc      = '0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && diff_m[i]) begin
                lzc      = 5'(23 - i);
                lz_found = 1'b1;
            end
        end
        add_exp = $signed({3'b000, e_big}) - $signed({6'b000000, lzc});

        add_res = '0;
        if (a_zero && b_zero) begin
            add_res = '0;
        end else if (a_zero) begin
            add_res = {sb_eff, B[30:0]};
        end else if (b_zero) begin
            add_res = A;
        end else if (sa == sb_eff) begin
            if (sum[24]) begin
                if (e_big == 8'd254) add_res = {s_big, 8'hFF, 23'd0};
                else                 add_res = {s_big, e_big + 8'd1, sum[23:1]};
            end else begin
                add_res = {s_big, e_big, sum[22:0]};
            end
        end else if (diff_m == 24'd0) begin
            add_res = '0;
        end else if (add_exp <= 11'sd0) begin
            add_res = '0;
        end else begin
            add_res = {s_big, add_exp[7:0], 23'(diff_m << lzc)};
        end
    end

    // ---------------------------------------------------------------- multiply
    logic [24:0]        prod_hi;
    logic [22:0]        mul_frac;
    logic signed [10:0] mul_exp;
    logic [31:0]        mul_res;

    always_comb begin
        prod_hi  = 25'(({24'd0, ma} * {24'd0, mb}) >> 23);
        mul_frac = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
        mul_exp  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
                 + $signed({10'd0, prod_hi[24]});

        mul_res = '0;
        if (a_zero || b_zero)          mul_res = '0;
        else if (mul_exp >= 11'sd255)  mul_res = {sa ^ sb, 8'hFF, 23'd0};
        else if (mul_exp <= 11'sd0)    mul_res = '0;
        else                           mul_res = {sa ^ sb, mul_exp[7:0], mul_frac};
    end

    // ---------------------------------------------------------------- divide
    // Restoring division of the 24-bit mantissas; quo[24] has weight 1.0, quo[0] weight 2^-24.
    logic [25:0]        rem;
    logic [24:0]        quo;
    logic [22:0]        div_frac;
    logic signed [10:0] div_exp;
    logic [31:0]        div_res;

    always_comb begin
        rem = {2'b00, ma};
        quo = '0;
        for (int i = 24; i >= 0; i--) begin
            if (rem >= {2'b00, mb}) begin
                quo[i] = 1'b1;
                rem    = rem - {2'b00, mb};
            end
            rem = rem << 1;
        end
        div_frac = quo[24] ? quo[23:1] : quo[22:0];
        div_exp  = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 11'sd126
                 + $signed({10'd0, quo[24]});

        div_res = '0;
        if (a_zero)                    div_res = '0;
        else if (div_exp >= 11'sd255)  div_res = {sa ^ sb, 8'hFF, 23'd0};
        else if (div_exp <= 11'sd0)    div_res = '0;
        else                           div_res = {sa ^ sb, div_exp[7:0], div_frac};
    end

    // ---------------------------------------------------------------- select and register
    logic [31:0] result_d, result_q;
    logic        zero_division_d, zero_division_q;

    always_comb begin
        result_d        = '0;
        zero_division_d = 1'b0;
        if (en) begin
            // A zero divisor wins over Inf/NaN operands.
            if (op_sel == OP_DIV && b_zero) begin
                zero_division_d = 1'b1;
            end else if (a_spec || b_spec) begin
                result_d = QNAN;
            end else begin
                case (op_sel)
                    OP_ADD, OP_SUB: result_d = add_res;
                    OP_MUL:         result_d = mul_res;
                    default:        result_d = div_res;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; the reset branch sits in the sensitivity list so it acts without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q        <= '0;
            zero_division_q <= 1'b0;
        end else begin
            result_q        <= result_d;
            zero_division_q <= zero_division_d;
        end
    end

    assign result        = result_q;
    assign zero_division = zero_division_q;

endmodule

// File: tb/tb_fpu.sv
// Directed-vector bench for fpu: a table of hand-computed results plus
// short sequences for reset timing and input changes between edges.
module tb_fpu;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        zero_division;

    int n_checks = 0;
    int n_fail   = 0;

    fpu dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .op            (op),
        .A             (A),
        .B             (B),
        .result        (result),
        .zero_division (zero_division)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act_res, input logic act_zd,
                         input logic [31:0] exp_res, input logic exp_zd);
        n_checks++;
        if (act_res !== exp_res || act_zd !== exp_zd) begin
            n_fail++;
            $display("FAIL %s: result=%08h zero_division=%b, expected result=%08h zero_division=%b",
                     name, act_res, act_zd, exp_res, exp_zd);
        end
    endtask

    // Drive at the falling edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic v_en, input logic [1:0] v_op, input logic [31:0] v_a,
                         input logic [31:0] v_b);
        @(negedge clk);
        en = v_en;
        op = v_op;
        A  = v_a;
        B  = v_b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            en  op     A             B             result        zd
        vecs.push_back('{1'b1, 2'b00, 32'h40400000, 32'h40000000, 32'h40A00000, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 32'h40400000, 32'h40000000, 32'h3F800000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 32'h40400000, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 2'b00, 32'h40400000, 32'h40000000, 32'h40A00000, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 32'h00800000, 32'h00180000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 32'h40400000, 32'h40400000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 32'h3F800000, 32'h3F000000, 32'h3FC00000, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 32'h40000000, 32'h40400000, 32'hBF800000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 32'h7FC00000, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 32'h3F800000, 32'h34000000, 32'h3F7FFFFE, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 32'h00000000, 32'hC0000000, 32'hC0000000, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 32'h00000000, 32'h40000000, 32'hC0000000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 32'h3F800000, 32'h00180000, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 2'b11, 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 32'h3F800000, 32'h7F800000, 32'h7FC00000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 32'hFF000000, 32'h40000000, 32'hFF800000, 1'b0});

        // Reset asserted with a real rising transition, checked before any clock edge.
        rst = 1'b0;
        en  = 1'b0;
        op  = 2'b00;
        A   = '0;
        B   = '0;
        #1 rst = 1'b1;
        #1 check("reset_immediate", result, zero_division, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check("reset_held", result, zero_division, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), result, zero_division, vecs[i].res, vecs[i].zd);
        end

        // Only the values present at the edge matter; the result then holds while inputs move.
        @(negedge clk);
        en = 1'b1;
        op = 2'b11;
        A  = 32'h40400000;
        B  = 32'h00000000;
        #4;
        op = 2'b00;
        B  = 32'h40000000;
        @(posedge clk);
        #1 check("edge_sample", result, zero_division, 32'h40A00000, 1'b0);
        op = 2'b11;
        B  = 32'h00000000;
        #2 check("hold_between_edges", result, zero_division, 32'h40A00000, 1'b0);

        // Reset pulsed between edges clears the output at once.
        apply(1'b1, 2'b00, 32'h40400000, 32'h40000000);
        check("pre_reset_add", result, zero_division, 32'h40A00000, 1'b0);
        #1 rst = 1'b1;
        #1 check("midstream_reset", result, zero_division, 32'h0, 1'b0);
        #1 rst = 1'b0;
        apply(1'b1, 2'b10, 32'h7F000000, 32'h40000000);
        check("mul_overflow_after_reset", result, zero_division, 32'h7F800000, 1'b0);

        // An operation sampled while reset is high is discarded; the first edge with rst=0 counts.
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        op  = 2'b11;
        A   = 32'h40400000;
        B   = 32'h00000000;
        @(posedge clk);
        #1 check("op_during_reset", result, zero_division, 32'h0, 1'b0);
        apply(1'b1, 2'b10, 32'h40400000, 32'h40000000);
        check("op_during_reset_held", result, zero_division, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("first_op_after_reset", result, zero_division, 32'h40C00000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
